mac_accumulator4: RTL and testbench

MAC_ACCUMULATOR4 -- requirements
Module: mac_accumulator4

---
 rtl/mac_accumulator4.sv | 111 +++++++++++
 tb/tb_mac_accumulator4.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator4.sv
// Multiply-accumulate of 4-bit unsigned operand pairs with valid/ready handshakes.
// Define MAC_ACCUMULATOR4_SAT_EN to saturate the accumulator instead of wrapping.
module mac_accumulator4 #(
  parameter int ACC_W     = 12,
  parameter int MAX_TERMS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [4:0]       term_count,
  output logic             overflow
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACC   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [4:0] MAX_CNT = 5'(MAX_TERMS);

  logic [1:0]       state_q, state_d;
  logic [7:0]       prod_q, prod_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             accept;
  logic [4:0]       cnt_inc;
  logic [ACC_W:0]   sum;

  assign in_ready   = ((state_q == S_IDLE) || (state_q == S_ACC)) && !clear;
  assign accept     = in_valid && in_ready;
  assign out_valid  = (state_q == S_DONE);
  assign acc_out    = acc_q;
  assign term_count = cnt_q;
  assign overflow   = ovf_q;
  assign cnt_inc    = cnt_q + 5'd1;
  // One extra bit on the sum exposes the carry used for overflow detection.
  assign sum        = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, prod_q};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    // An empty product slot holds zero so idle cycles add nothing.
    prod_d  = accept ? ({4'b0, a} * {4'b0, b}) : 8'd0;

    if (state_q != S_DONE) begin
      acc_d = sum[ACC_W-1:0];
      if (sum[ACC_W]) begin
        ovf_d = 1'b1;
`ifdef MAC_ACCUMULATOR4_SAT_EN
        acc_d = '1;
`else
        acc_d = sum[ACC_W-1:0];
`endif
      end
    end

    case (state_q)
      S_IDLE, S_ACC: begin
        if (accept) begin
          cnt_d   = cnt_inc;
          state_d = (last || (cnt_inc == MAX_CNT)) ? S_FLUSH : S_ACC;
        end
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (clear) begin
      state_d = S_IDLE;
      prod_d  = '0;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      prod_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mac_accumulator4.sv
// Scoreboard bench: a 12-bit and an 8-bit accumulator share one stimulus stream.
module tb_mac_accumulator4;

`ifdef MAC_ACCUMULATOR4_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] acc;
    logic [4:0]  cnt;
    logic        ovf;
  } res_t;

  typedef struct packed {
    logic        ir;
    logic        ov;
    logic [31:0] acc12;
    logic [31:0] acc8;
    logic [4:0]  cnt;
    logic        ovf12;
    logic        ovf8;
  } st_t;

  logic clk = 1'b0;
  logic rst, clear, in_valid, last, out_ready;
  logic [3:0] a, b;

  logic        ir12, ov12, of12, ir8, ov8, of8;
  logic [11:0] acc12;
  logic [7:0]  acc8;
  logic [4:0]  cnt12, cnt8;

  res_t q12[$];
  res_t q8[$];
  st_t  stq[$];
  bit   end_req = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  mac_accumulator4 #(.ACC_W(12), .MAX_TERMS(16)) dut12 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(ir12),
    .a(a), .b(b), .last(last), .out_valid(ov12), .out_ready(out_ready),
    .acc_out(acc12), .term_count(cnt12), .overflow(of12)
  );

  mac_accumulator4 #(.ACC_W(8), .MAX_TERMS(16)) dut8 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(ir8),
    .a(a), .b(b), .last(last), .out_valid(ov8), .out_ready(out_ready),
    .acc_out(acc8), .term_count(cnt8), .overflow(of8)
  );

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: all comparisons happen here, on the falling edge.
  always @(negedge clk) begin
    st_t  s;
    res_t r;
    cyc++;
    while (stq.size() > 0) begin
      s = stq.pop_front();
      cmp("in_ready12", 32'(ir12), 32'(s.ir));
      cmp("in_ready8", 32'(ir8), 32'(s.ir));
      cmp("out_valid12", 32'(ov12), 32'(s.ov));
      cmp("out_valid8", 32'(ov8), 32'(s.ov));
      cmp("acc12", 32'(acc12), s.acc12);
      cmp("acc8", 32'(acc8), s.acc8);
      cmp("cnt12", 32'(cnt12), 32'(s.cnt));
      cmp("cnt8", 32'(cnt8), 32'(s.cnt));
      cmp("ovf12", 32'(of12), 32'(s.ovf12));
      cmp("ovf8", 32'(of8), 32'(s.ovf8));
    end
    if (ov12 && out_ready) begin
      if (q12.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_result12: acc %0d, no result expected", acc12);
      end else begin
        r = q12.pop_front();
        cmp("result_acc12", 32'(acc12), r.acc);
        cmp("result_cnt12", 32'(cnt12), 32'(r.cnt));
        cmp("result_ovf12", 32'(of12), 32'(r.ovf));
      end
    end
    if (ov8 && out_ready) begin
      if (q8.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_result8: acc %0d, no result expected", acc8);
      end else begin
        r = q8.pop_front();
        cmp("result_acc8", 32'(acc8), r.acc);
        cmp("result_cnt8", 32'(cnt8), 32'(r.cnt));
        cmp("result_ovf8", 32'(of8), 32'(r.ovf));
      end
    end
    if (end_req || cyc > 5000) begin
      if (!end_req) begin
        tests++; fails++;
        $display("FAIL timeout: cycle %0d, limit 5000", cyc);
      end
      cmp("pending12", 32'(q12.size()), 32'd0);
      cmp("pending8", 32'(q8.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] av, input logic [3:0] bv, input logic lv);
    in_valid = 1'b1; a = av; b = bv; last = lv;
    tick();
    in_valid = 1'b0; last = 1'b0;
  endtask

  task automatic expect_st(input logic ir, input logic ov, input int ac12, input int ac8,
                           input int cnt, input logic o12, input logic o8);
    st_t s;
    s.ir = ir; s.ov = ov; s.acc12 = 32'(ac12); s.acc8 = 32'(ac8);
    s.cnt = 5'(cnt); s.ovf12 = o12; s.ovf8 = o8;
    stq.push_back(s);
  endtask

  task automatic expect_idle();
    expect_st(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic push_res(input int ac12, input int ac8, input int cnt, input logic o12, input logic o8);
    res_t r;
    r.cnt = 5'(cnt);
    r.acc = 32'(ac12); r.ovf = o12; q12.push_back(r);
    r.acc = 32'(ac8);  r.ovf = o8;  q8.push_back(r);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; last = 1'b0;
    out_ready = 1'b1; a = '0; b = '0;
    tick(); tick();
    rst = 1'b0;
    expect_idle();

    // Basic: 15 + 225 + 0 = 240.
    push_res(240, 240, 3, 1'b0, 1'b0);
    send(4'd3, 4'd5, 1'b0);
    send(4'd15, 4'd15, 1'b0);
    send(4'd0, 4'd9, 1'b1);
    expect_st(1'b0, 1'b0, 240, 240, 3, 1'b0, 1'b0);
    tick(); tick();
    expect_idle();

    // Term limit: 16 x 225 = 3600; the 8-bit copy wraps to 16 or saturates.
    push_res(3600, SAT ? 255 : 16, 16, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      send(4'd15, 4'd15, 1'b0);
      if (i == 4) expect_st(1'b1, 1'b0, 900, SAT ? 255 : 132, 5, 1'b0, 1'b1);
    end
    expect_st(1'b0, 1'b0, 3375, SAT ? 255 : 47, 16, 1'b0, 1'b1);
    tick(); tick();
    expect_idle();

    // Overflow: 225 + 225 = 450, wraps to 194 in 8 bits.
    push_res(450, SAT ? 255 : 194, 2, 1'b0, 1'b1);
    send(4'd15, 4'd15, 1'b0);
    send(4'd15, 4'd15, 1'b1);
    tick(); tick();
    expect_idle();

    // Clear with a pending term: the term is refused and all state drops.
    send(4'd1, 4'd2, 1'b0);
    send(4'd3, 4'd4, 1'b0);
    in_valid = 1'b1; a = 4'd5; b = 4'd5; clear = 1'b1;
    expect_st(1'b0, 1'b0, 2, 2, 2, 1'b0, 1'b0);
    tick();
    clear = 1'b0; in_valid = 1'b0;
    expect_idle();
    tick(); tick();
    expect_idle();

    // Backpressure: result held for 5 cycles, then released.
    out_ready = 1'b0;
    push_res(26, 26, 2, 1'b0, 1'b0);
    send(4'd2, 4'd3, 1'b0);
    send(4'd4, 4'd5, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      expect_st(1'b0, 1'b1, 26, 26, 2, 1'b0, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    expect_idle();

    // Reset during FLUSH must never present a result.
    send(4'd7, 4'd7, 1'b0);
    send(4'd7, 4'd7, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_idle();
    tick(); tick(); tick();
    expect_idle();
    tick();
    end_req = 1'b1;
  end

endmodule
